// File: rtl/serial_tx_stage.sv
// serial_tx_stage
//   Buffers the CPU's 7-bit character stream in a small FIFO and sends each
//   character as an asynchronous UART frame: 1 start bit, 8 data bits
//   (LSB first, bit 7 always 0), then 1 stop bit.
//   Build option: define SERIAL_TX_PARITY_EN to insert an even-parity bit
//   between the data bits and the stop bit. This gives 11 bit times per frame.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//   FIFO_DEPTH    character buffer entries (power of 2, >= 2)
//   CNTW          width of fifo_count
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous reset, active low
//   char_in     character code, 7'h00 = no character this cycle
//   txd         serial line, idles high
//   busy        frame on the line or characters still buffered
//   fifo_full   buffer holds FIFO_DEPTH entries
//   fifo_count  buffered characters, not counting the one being shifted
//   overflow    sticky, set when a character had to be dropped

module serial_tx_stage #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int CNTW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      char_in,
    output logic            txd,
    output logic            busy,
    output logic            fifo_full,
    output logic [CNTW-1:0] fifo_count,
    output logic            overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state, state_next;
    logic [BW-1:0]   baud_cnt, baud_next;
    logic [2:0]      bit_idx, bit_next;
    logic [7:0]      shift_reg;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count, count_next;
    logic            baud_done;
    logic            pop, push_req, push_ok;
    logic            txd_next;

    assign baud_done  = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign push_req   = (char_in != 7'h00);
    // A full buffer can still take a character when a slot frees up on the
    // same edge.
    assign push_ok    = push_req && ((count != CNTW'(FIFO_DEPTH)) || pop);
    assign fifo_count = count;

    // Next-state logic. A pop happens only on entry to START, either from
    // IDLE or directly from the last STOP cycle, so back-to-back frames leave
    // no idle gap on the line.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + BW'(1);
        bit_next   = bit_idx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_next = '0;
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (baud_done) begin
                    state_next = DATA;
                    baud_next  = '0;
                    bit_next   = 3'd0;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (baud_done) begin
                    state_next = STOP;
                    baud_next  = '0;
                end
            end
`endif
            STOP: begin
                if (baud_done) begin
                    baud_next = '0;
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase
    end

    // txd is registered, so it is computed from the state being entered.
    // The shift register is already loaded before DATA is reached.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_reg[bit_next];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  txd_next = ^shift_reg;
`endif
            default: txd_next = 1'b1;
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push_ok, pop})
            2'b10:   count_next = count + CNTW'(1);
            2'b01:   count_next = count - CNTW'(1);
            default: count_next = count;
        endcase
    end

    // Buffer storage has no reset. Only slots between the pointers are
    // ever read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {1'b0, char_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            txd       <= 1'b1;
            busy      <= 1'b0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            txd       <= txd_next;
            count     <= count_next;
            fifo_full <= (count_next == CNTW'(FIFO_DEPTH));
            busy      <= (state_next != IDLE) || (count_next != '0);
            if (pop) begin
                shift_reg <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
